data_mem_lsu: RTL

- Parametrised byte-addressable data memory with an integrated load/store unit for the multi-cycle RISC-V core.
- Supports RV32I access sizes: LB/LH/LW/LBU/LHU and SB/SH/SW, selected by funct3.
- Provides byte-lane writes, sign/zero extension, alignment and range checking with fault reporting.
- Uses a valid/ready request/response handshake with configurable response latency.

---
 rtl/data_mem_lsu.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/data_mem_lsu.sv
// Byte-addressable data memory with an RV32I load/store unit front end.
// Single outstanding request, valid/ready on both sides, fixed response latency.
module data_mem_lsu #(
  parameter int ADDR_W      = 32,
  parameter int DEPTH_BYTES = 4096,
  parameter int LATENCY     = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_fault,
  output logic [1:0]        resp_fault_code
);

  localparam int IDX_W = $clog2(DEPTH_BYTES);
  localparam int CNT_W = 4;
  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W+1)'(DEPTH_BYTES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] count;
  logic [7:0]       mem [DEPTH_BYTES];

  logic             is_byte;
  logic             is_half;
  logic             is_word;
  logic             legal;
  logic             misaligned;
  logic             out_of_range;
  logic [1:0]       size_m1;
  logic [ADDR_W:0]  last_addr;
  logic [1:0]       fault_code;
  logic             accept;
  logic             do_write;
  logic [IDX_W-1:0] idx0;
  logic [IDX_W-1:0] idx1;
  logic [IDX_W-1:0] idx2;
  logic [IDX_W-1:0] idx3;
  logic [31:0]      raw;
  logic [31:0]      ext;

  // Request decode: legality, alignment and range are all judged on the live request fields.
  always_comb begin
    is_byte    = (req_funct3[1:0] == 2'b00);
    is_half    = (req_funct3[1:0] == 2'b01);
    is_word    = (req_funct3[1:0] == 2'b10);
    if (req_we) begin
      legal = !req_funct3[2] && (req_funct3[1:0] != 2'b11);
    end else begin
      legal = (req_funct3[1:0] != 2'b11) && !(req_funct3[2] && req_funct3[1]);
    end
    misaligned = (is_half && req_addr[0]) || (is_word && (req_addr[1:0] != 2'b00));
    size_m1    = is_word ? 2'd3 : (is_half ? 2'd1 : 2'd0);
    last_addr  = {1'b0, req_addr} + {{(ADDR_W-1){1'b0}}, size_m1};
    out_of_range = (last_addr >= DEPTH_LIM);

    if (!legal) begin
      fault_code = 2'b11;
    end else if (misaligned) begin
      fault_code = 2'b01;
    end else if (out_of_range) begin
      fault_code = 2'b10;
    end else begin
      fault_code = 2'b00;
    end

    accept   = (state == S_IDLE) && req_valid;
    do_write = accept && req_we && (fault_code == 2'b00);

    idx0 = req_addr[IDX_W-1:0];
    idx1 = idx0 + IDX_W'(1);
    idx2 = idx0 + IDX_W'(2);
    idx3 = idx0 + IDX_W'(3);
    raw  = {mem[idx3], mem[idx2], mem[idx1], mem[idx0]};

    case (req_funct3)
      3'b000:  ext = {{24{raw[7]}}, raw[7:0]};
      3'b001:  ext = {{16{raw[15]}}, raw[15:0]};
      3'b100:  ext = {24'h0, raw[7:0]};
      3'b101:  ext = {16'h0, raw[15:0]};
      default: ext = raw;
    endcase
  end

  // Storage has no reset so committed stores survive a reset pulse.
  always_ff @(posedge clk) begin
    if (rst_n && do_write) begin
      mem[idx0] <= req_wdata[7:0];
      if (!is_byte) begin
        mem[idx1] <= req_wdata[15:8];
      end
      if (is_word) begin
        mem[idx2] <= req_wdata[23:16];
        mem[idx3] <= req_wdata[31:24];
      end
    end
  end

  // Control FSM with all handshake and response outputs registered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      count           <= '0;
      req_ready       <= 1'b1;
      resp_valid      <= 1'b0;
      resp_rdata      <= '0;
      resp_fault      <= 1'b0;
      resp_fault_code <= 2'b00;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            resp_rdata      <= (req_we || (fault_code != 2'b00)) ? 32'h0 : ext;
            resp_fault      <= (fault_code != 2'b00);
            resp_fault_code <= fault_code;
            req_ready       <= 1'b0;
            if (LATENCY == 1) begin
              state      <= S_RESP;
              resp_valid <= 1'b1;
            end else begin
              state <= S_WAIT;
              count <= CNT_W'(LATENCY - 1);
            end
          end
        end
        S_WAIT: begin
          if (count == CNT_W'(1)) begin
            state      <= S_RESP;
            resp_valid <= 1'b1;
            count      <= '0;
          end else begin
            count <= count - CNT_W'(1);
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            state           <= S_IDLE;
            resp_valid      <= 1'b0;
            req_ready       <= 1'b1;
            resp_rdata      <= '0;
            resp_fault      <= 1'b0;
            resp_fault_code <= 2'b00;
          end
        end
        default: begin
          state     <= S_IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
